beat_scheduler: RTL and testbench

//  Tempo controller for the DDR game loop. It owns a free-running divider counter and

---
 rtl/beat_scheduler.sv | 173 +++++++++++++++++
 tb/tb_beat_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/beat_scheduler.sv
// Tempo controller: free-running divider, selectable beat tap, IDLE/COUNTDOWN/RUN/PAUSE
// sequencing and one-cycle beat strobes. Optional tempo speed-up is enabled by SPEEDUP_EN.
module beat_scheduler #(
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned SEL_W           = 5,
  parameter int unsigned BEAT_W          = 16,
  parameter int unsigned DEFAULT_TAP     = 23,
  parameter int unsigned MIN_TAP         = 18,
  parameter int unsigned COUNTDOWN_BEATS = 4,
  parameter int unsigned SPEEDUP_BEATS   = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic [SEL_W-1:0]  tap_sel,
  input  logic              tap_load,
  output logic              tick,
  output logic [BEAT_W-1:0] beat_count,
  output logic [1:0]        state,
  output logic [SEL_W-1:0]  cur_tap
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    RUN       = 2'd2,
    PAUSE     = 2'd3
  } state_t;

  localparam int unsigned CD_W = $clog2(COUNTDOWN_BEATS + 1);

  if (COUNTDOWN_BEATS < 1 || SPEEDUP_BEATS < 1 || MIN_TAP >= CNT_W ||
      DEFAULT_TAP >= CNT_W) begin : g_bad_cfg
    $error("beat_scheduler: illegal parameter set");
  end

  function automatic logic tap_bit(input logic [CNT_W-1:0] c, input logic [SEL_W-1:0] t);
    logic [CNT_W-1:0] s;
    s = c >> t;
    return s[0];
  endfunction

  function automatic logic [SEL_W-1:0] clamp_tap(input logic [SEL_W-1:0] t);
    int unsigned tv;
    tv = 32'(t);
    if (tv < MIN_TAP)        return SEL_W'(MIN_TAP);
    else if (tv > CNT_W - 1) return SEL_W'(CNT_W - 1);
    else                     return t;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              prev_q, prev_d;
  logic              tick_q, tick_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [SEL_W-1:0]  tap_q, tap_d;
  logic [CD_W-1:0]   cd_q, cd_d;
  logic              bit_now;
  logic              beat_evt;

`ifdef SPEEDUP_EN
  localparam int unsigned SPD_W = $clog2(SPEEDUP_BEATS + 1);
  logic [SPD_W-1:0]  spd_q, spd_d;
`endif

  assign bit_now  = tap_bit(cnt_q, tap_q);
  assign beat_evt = bit_now & ~prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    tick_d  = 1'b0;
    beat_d  = beat_q;
    tap_d   = tap_q;
    cd_d    = cd_q;
`ifdef SPEEDUP_EN
    spd_d   = spd_q;
`endif
    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      prev_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tap_load) tap_d = clamp_tap(tap_sel);
          if (start) begin
            state_d = COUNTDOWN;
            cnt_d   = '0;
            prev_d  = 1'b0;
            beat_d  = '0;
            cd_d    = CD_W'(COUNTDOWN_BEATS);
`ifdef SPEEDUP_EN
            spd_d   = '0;
`endif
          end
        end
        COUNTDOWN: begin
          cnt_d  = cnt_q + 1'b1;
          prev_d = bit_now;
          tick_d = beat_evt;
          // Counting on the registered strobe keeps the final countdown tick visible in COUNTDOWN.
          if (tick_q) begin
            cd_d = cd_q - 1'b1;
            if (cd_q == CD_W'(1)) state_d = RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            prev_d = bit_now;
            tick_d = beat_evt;
            if (beat_evt) begin
              if (beat_q != '1) beat_d = beat_q + 1'b1;
`ifdef SPEEDUP_EN
              if (spd_q == SPD_W'(SPEEDUP_BEATS - 1)) begin
                spd_d = '0;
                if (tap_q > SEL_W'(MIN_TAP)) begin
                  tap_d  = tap_q - 1'b1;
                  // Resync edge detector to the new tap so the switch itself is not a beat.
                  prev_d = tap_bit(cnt_q, tap_q - 1'b1);
                end
              end else begin
                spd_d = spd_q + 1'b1;
              end
`endif
            end
          end
        end
        PAUSE: begin
          if (!pause) state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
      beat_q  <= '0;
      tap_q   <= SEL_W'(DEFAULT_TAP);
      cd_q    <= '0;
`ifdef SPEEDUP_EN
      spd_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      tick_q  <= tick_d;
      beat_q  <= beat_d;
      tap_q   <= tap_d;
      cd_q    <= cd_d;
`ifdef SPEEDUP_EN
      spd_q   <= spd_d;
`endif
    end
  end

  assign tick       = tick_q;
  assign beat_count = beat_q;
  assign state      = state_q;
  assign cur_tap    = tap_q;

endmodule

// File: tb/tb_beat_scheduler.sv
// Directed bench for beat_scheduler with CNT_W=8, MIN_TAP=1, COUNTDOWN_BEATS=2, DEFAULT_TAP=3.
// Speed-up sequence runs only when SPEEDUP_EN is defined.
module tb_beat_scheduler;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start, pause, stop, tap_load;
  logic [4:0] tap_sel;
  logic       tick;
  logic [3:0] beat_count;
  logic [1:0] state;
  logic [4:0] cur_tap;

  int tests = 0;
  int fails = 0;
  int n = 0;
  int tq[$];

  always #5 clock = ~clock;

  beat_scheduler #(
    .CNT_W(8), .SEL_W(5), .BEAT_W(4), .DEFAULT_TAP(3), .MIN_TAP(1),
    .COUNTDOWN_BEATS(2), .SPEEDUP_BEATS(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .pause(pause), .stop(stop),
    .tap_sel(tap_sel), .tap_load(tap_load), .tick(tick), .beat_count(beat_count),
    .state(state), .cur_tap(cur_tap)
  );

  typedef struct {
    logic       start, pause, stop, tl;
    logic [4:0] sel;
    logic [1:0] e_state;
    logic       e_tick;
    logic [3:0] e_beat;
    logic [4:0] e_tap;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    n++;
    if (tick) tq.push_back(n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  2'd0, 1'b0, 4'd3, 5'd1};
    vt[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 2'd0, 1'b0, 4'd3, 5'd7};
    vt[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  2'd0, 1'b0, 4'd3, 5'd7};
    vt[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd7,  2'd0, 1'b0, 4'd3, 5'd7};
    vt[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd4,  2'd0, 1'b0, 4'd3, 5'd4};
    vt[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd2,  2'd0, 1'b0, 4'd3, 5'd4};
    vt[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd2,  2'd0, 1'b0, 4'd3, 5'd4};
    vt[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd2,  2'd0, 1'b0, 4'd3, 5'd4};
    vt[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  2'd0, 1'b0, 4'd3, 5'd1};

    reset_n = 1'b0; start = 0; pause = 0; stop = 0; tap_load = 0; tap_sel = '0;

    // Reset state
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();
    chk("rst_tick", tick, 0);
    chk("rst_beat", beat_count, 0);
    chk("rst_state", state, 0);
    chk("rst_tap", cur_tap, 3);

    // Tap 2 start: tick timing and countdown
    tap_load = 1; tap_sel = 5'd2;
    cyc();
    tap_load = 0;
    chk("load_tap2", cur_tap, 2);
    start = 1;
    cyc();
    start = 0;
    n = 0;
    tq.delete();
    chk("start_state", state, 1);
    repeat (30) begin
      cyc();
      if (n == 5)  chk("tick1_state", state, 1);
      if (n == 13) chk("tick2_state", state, 1);
      if (n == 14) chk("run_after_cd", state, 2);
      if (n == 20) chk("beat_before_t3", beat_count, 0);
      if (n == 21) chk("beat_after_t3", beat_count, 1);
      if (n == 29) chk("beat_after_t4", beat_count, 2);
    end
    chk("tick_cnt_30", tq.size(), 4);
    if (tq.size() >= 4) begin
      chk("first_tick_at", tq[0], 5);
      chk("tick_period", tq[1] - tq[0], 8);
      chk("tick4_at", tq[3], 29);
    end

    // Pause 20 cycles mid-RUN
    repeat (2) cyc();
    pause = 1;
    repeat (20) begin
      cyc();
      if (n == 33) chk("pause_state", state, 3);
    end
    chk("pause_state_end", state, 3);
    chk("pause_beat_frozen", beat_count, 2);
    pause = 0;
    cyc();
    chk("resume_state", state, 2);
    repeat (5) cyc();
    chk("resume_tick", tick, 1);
    chk("resume_beat", beat_count, 3);
    chk("pause_tick_cnt", tq.size(), 5);

    // tap_load ignored in RUN; stop beats pause/start
    tap_load = 1; tap_sel = 5'd5;
    cyc();
    tap_load = 0;
    chk("run_load_ignored", cur_tap, 2);
    stop = 1; pause = 1; start = 1;
    cyc();
    stop = 0; pause = 0; start = 0;
    chk("stop_state", state, 0);
    chk("stop_tick", tick, 0);
    chk("stop_beat_held", beat_count, 3);
    repeat (3) cyc();
    chk("idle_state", state, 0);
    chk("idle_beat_held", beat_count, 3);

    // IDLE vector table
    for (int unsigned i = 0; i < 9; i++) begin
      start = vt[i].start; pause = vt[i].pause; stop = vt[i].stop;
      tap_load = vt[i].tl; tap_sel = vt[i].sel;
      cyc();
      chk($sformatf("vec%0d_state", i), state, vt[i].e_state);
      chk($sformatf("vec%0d_tick", i), tick, vt[i].e_tick);
      chk($sformatf("vec%0d_beat", i), beat_count, vt[i].e_beat);
      chk($sformatf("vec%0d_tap", i), cur_tap, vt[i].e_tap);
    end
    start = 0; pause = 0; stop = 0; tap_load = 0;

    // Tap 1: beat_count saturation, then async reset mid-RUN
    start = 1;
    cyc();
    start = 0;
    n = 0;
    tq.delete();
    chk("restart_beat_clr", beat_count, 0);
    repeat (99) begin
      cyc();
      if (n == 63) chk("beat_14", beat_count, 14);
      if (n == 67) chk("beat_sat", beat_count, 15);
    end
    chk("beat_sat_hold", beat_count, 15);
    chk("sat_tick", tick, 1);
    chk("sat_tick_cnt", tq.size(), 25);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_tick", tick, 0);
    chk("arst_beat", beat_count, 0);
    chk("arst_state", state, 0);
    chk("arst_tap", cur_tap, 3);
    @(posedge clock);
    #1 reset_n = 1'b1;
    cyc();
    chk("arst_release_state", state, 0);

`ifdef SPEEDUP_EN
    begin
      int exp6[16] = '{9, 25, 41, 57, 73, 89, 93, 101, 109, 117, 119, 123, 127, 131, 135, 139};
      tap_load = 1; tap_sel = 5'd3;
      cyc();
      tap_load = 0;
      start = 1;
      cyc();
      start = 0;
      n = 0;
      tq.delete();
      repeat (140) begin
        cyc();
        if (n == 88)  chk("spd_tap_before", cur_tap, 3);
        if (n == 89)  chk("spd_tap_2", cur_tap, 2);
        if (n == 117) chk("spd_tap_1", cur_tap, 1);
        if (n == 117) chk("spd_beat_8", beat_count, 8);
      end
      chk("spd_tap_floor", cur_tap, 1);
      chk("spd_tick_cnt", tq.size(), 16);
      for (int i = 0; i < 16; i++)
        if (i < tq.size()) chk($sformatf("spd_tick%0d", i), tq[i], exp6[i]);
      stop = 1;
      cyc();
      stop = 0;
      chk("spd_tap_after_stop", cur_tap, 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
